// File: rtl/fft_iter.sv
// fft_iter: iterative in-place radix-2 decimation-in-time FFT, one butterfly per clock.
//
// Parameters:
//   LOG2N : log2 of the transform size N (2..10)
//   DW    : two's-complement width of each real / imaginary part
//   FRAC  : fraction bits of the fixed-point format Q(DW-FRAC-1).FRAC
//
// Ports:
//   ck        : clock, rising edge
//   rst_n     : synchronous active-low reset (state and counters only; tables kept)
//   tw_we     : twiddle table write enable, honoured only while idle
//   tw_addr   : twiddle index k (0..N/2-1)
//   tw_data   : {re, im} of W^k = exp(-j*2*pi*k/N)
//   in_valid  : input sample valid
//   in_ready  : block accepts an input sample (idle or loading)
//   in_data   : complex input sample {re, im}
//   out_valid : output bin valid (unloading only)
//   out_ready : downstream accepts an output bin
//   out_data  : complex output bin {re, im}, natural order
//   out_last  : marks bin N-1
//   busy      : high whenever a frame is in flight
//
// Build option: define FFT_STAGE_SCALE_EN to halve both butterfly outputs in every
// stage (overall 1/N scaling). Without it no scaling is applied.
module fft_iter #(
   parameter int unsigned LOG2N = 3,
   parameter int unsigned DW    = 16,
   parameter int unsigned FRAC  = 11
) (
   input  logic                 ck,
   input  logic                 rst_n,
   input  logic                 tw_we,
   input  logic [LOG2N-2:0]     tw_addr,
   input  logic [2*DW-1:0]      tw_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*DW-1:0]      in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*DW-1:0]      out_data,
   output logic                 out_last,
   output logic                 busy
);

   localparam int unsigned N    = 2 ** LOG2N;
   localparam int unsigned HALF = N / 2;
   localparam int unsigned SW   = $clog2(LOG2N);

   typedef enum logic [1:0] {StIdle, StLoad, StCalc, StUnload} state_e;

   state_e               state_q, state_d;
   logic [LOG2N-1:0]     cnt_q, cnt_d;
   logic [SW-1:0]        stage_q, stage_d;
   logic [LOG2N-2:0]     bfly_q, bfly_d;
   logic [2*DW-1:0]      mem_q [N];
   logic [2*DW-1:0]      mem_d [N];
   logic [2*DW-1:0]      tw_q [HALF];
   logic [2*DW-1:0]      tw_d [HALF];

   // Butterfly datapath
   logic [LOG2N-1:0]     j_ext, m, k, addr_a, addr_b, tw_full;
   logic [LOG2N-2:0]     tw_idx;
   int unsigned          tw_sh;
   logic signed [DW-1:0] xa_re, xa_im, xb_re, xb_im, w_re, w_im;
   logic signed [DW-1:0] p_re, p_im, y0_re, y0_im, y1_re, y1_im;
   logic signed [2*DW:0] rr, ii, ri, ir, full_re, full_im;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < int'(LOG2N); i++) begin
         r[i] = v[LOG2N-1-i];
      end
      return r;
   endfunction

   always_comb begin
      // Address generation: a = (j/m)*2m + k, b = a + m, twiddle = k*N/(2m)
      j_ext   = {1'b0, bfly_q};
      m       = LOG2N'(1) << stage_q;
      k       = j_ext & (m - LOG2N'(1));
      addr_a  = ((j_ext & ~(m - LOG2N'(1))) << 1) | k;
      addr_b  = addr_a | m;
      tw_sh   = LOG2N - 1 - 32'(stage_q);
      tw_full = k << tw_sh;
      tw_idx  = tw_full[LOG2N-2:0];

      xa_re = mem_q[addr_a][2*DW-1:DW];
      xa_im = mem_q[addr_a][DW-1:0];
      xb_re = mem_q[addr_b][2*DW-1:DW];
      xb_im = mem_q[addr_b][DW-1:0];
      w_re  = tw_q[tw_idx][2*DW-1:DW];
      w_im  = tw_q[tw_idx][DW-1:0];

      // Full-precision partial products; the slice is floor(>>>FRAC) truncated to DW
      rr      = (2*DW+1)'(xb_re) * (2*DW+1)'(w_re);
      ii      = (2*DW+1)'(xb_im) * (2*DW+1)'(w_im);
      ri      = (2*DW+1)'(xb_re) * (2*DW+1)'(w_im);
      ir      = (2*DW+1)'(xb_im) * (2*DW+1)'(w_re);
      full_re = rr - ii;
      full_im = ri + ir;
      p_re    = full_re[FRAC+DW-1:FRAC];
      p_im    = full_im[FRAC+DW-1:FRAC];

      y0_re = xa_re + p_re;
      y0_im = xa_im + p_im;
      y1_re = xa_re - p_re;
      y1_im = xa_im - p_im;
`ifdef FFT_STAGE_SCALE_EN
      y0_re = y0_re >>> 1;
      y0_im = y0_im >>> 1;
      y1_re = y1_re >>> 1;
      y1_im = y1_im >>> 1;
`endif
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      stage_d   = stage_q;
      bfly_d    = bfly_q;
      mem_d     = mem_q;
      tw_d      = tw_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      busy      = (state_q != StIdle);

      unique case (state_q)
         StIdle: begin
            in_ready = 1'b1;
            if (tw_we) begin
               tw_d[tw_addr] = tw_data;
            end
            if (in_valid) begin
               mem_d[bitrev(cnt_q)] = in_data;
               cnt_d   = cnt_q + LOG2N'(1);
               state_d = StLoad;
            end
         end
         StLoad: begin
            in_ready = 1'b1;
            if (in_valid) begin
               mem_d[bitrev(cnt_q)] = in_data;
               if (cnt_q == LOG2N'(N - 1)) begin
                  cnt_d   = '0;
                  state_d = StCalc;
               end else begin
                  cnt_d = cnt_q + LOG2N'(1);
               end
            end
         end
         StCalc: begin
            mem_d[addr_a] = {y0_re, y0_im};
            mem_d[addr_b] = {y1_re, y1_im};
            if (bfly_q == '1) begin
               bfly_d = '0;
               if (stage_q == SW'(LOG2N - 1)) begin
                  stage_d = '0;
                  state_d = StUnload;
               end else begin
                  stage_d = stage_q + SW'(1);
               end
            end else begin
               bfly_d = bfly_q + (LOG2N-1)'(1);
            end
         end
         StUnload: begin
            out_valid = 1'b1;
            out_data  = mem_q[cnt_q];
            out_last  = (cnt_q == LOG2N'(N - 1));
            if (out_ready) begin
               if (cnt_q == LOG2N'(N - 1)) begin
                  cnt_d   = '0;
                  state_d = StIdle;
               end else begin
                  cnt_d = cnt_q + LOG2N'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge ck) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         stage_q <= '0;
         bfly_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
      end
   end

   // Data buffer and twiddle table survive reset; a partial frame is simply abandoned
   always_ff @(posedge ck) begin
      if (rst_n) begin
         mem_q <= mem_d;
         tw_q  <= tw_d;
      end
   end

endmodule

// File: doc/fft_iter.md
FFT_ITER -- requirements
Module: fft_iter

Interface
REQ-001 SHALL have parameter LOG2N, default 3, meaning log2 of the transform size N (range 2..10).
REQ-002 SHALL have parameter DW, default 16, meaning the two's-complement width of each real and imaginary part.
REQ-003 SHALL have parameter FRAC, default 11, meaning the fraction bits of the fixed-point format (Q(DW-FRAC-1).FRAC).
REQ-004 SHALL have port ck, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: the reset; synchronous, active-low.
REQ-006 SHALL have port tw_we, input, 1 bit: twiddle table write enable.
REQ-007 SHALL have port tw_addr, input, LOG2N-1 bits: twiddle index k, 0..N/2-1.
REQ-008 SHALL have port tw_data, input, 2*DW bits: {re,im} of W^k = exp(-j2πk/N).
REQ-009 SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block accepts an input sample.
REQ-011 SHALL have port in_data, input, 2*DW bits: complex input sample {re[2DW-1:DW], im[DW-1:0]}.
REQ-012 SHALL have port out_valid, output, 1 bit: output sample valid.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream accepts an output sample.
REQ-014 SHALL have port out_data, output, 2*DW bits: complex output bin, same packing as in_data.
REQ-015 SHALL have port out_last, output, 1 bit: high with out_valid on bin N-1.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, LOAD, CALC, UNLOAD; IDLE->LOAD on the first in_valid; LOAD->CALC after N accepted samples; CALC->UNLOAD after the last butterfly; UNLOAD->IDLE after the out_valid&out_ready transfer of bin N-1.
REQ-018 SHALL assert in_ready only in IDLE and LOAD; a sample transfers when in_valid&in_ready; the IDLE transfer is sample 0.
REQ-019 SHALL write input sample n to internal buffer address bitreverse(n, LOG2N).
REQ-020 SHALL perform an in-place radix-2 DIT FFT in CALC, one butterfly per cycle, stages s=0..LOG2N-1, N/2 butterflies per stage, CALC lasting exactly LOG2N*N/2 cycles.
REQ-021 SHALL compute, for stage s and butterfly j: m=2^s, k=j mod m, top address a=(j/m)*2m+k, bottom address b=a+m, twiddle index k*N/(2m); y0=x[a]+W*x[b], y1=x[a]-W*x[b].
REQ-022 SHALL form each complex product with full-precision partial products, take the real part as rr-ii and the imaginary part as ri+ir, arithmetic-shift the result right by FRAC (floor), and keep the low DW bits.
REQ-023 SHALL wrap all additions and subtractions modulo 2^DW per part, with no saturation.
REQ-024 SHALL present bins in natural order 0..N-1 in UNLOAD; out_data/out_last SHALL hold stable while out_valid&!out_ready.
REQ-025 SHALL ignore tw_we while busy=1; in IDLE it SHALL write tw_data to entry tw_addr at the clock edge.
REQ-026 SHALL accept a tw_we in IDLE coinciding with the first in_valid; the written entry is in effect before CALC.
REQ-027 SHALL keep out_valid low outside UNLOAD and in_ready low outside IDLE/LOAD.

Reset
REQ-028 SHALL, on rst_n=0 at a rising edge, enter IDLE and clear the sample counter and stage/butterfly counters, in every state including mid-CALC and mid-UNLOAD.
REQ-029 SHALL drive after reset: in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
REQ-030 SHALL not clear the twiddle table or the data buffer on reset; a partial frame is discarded.

Configuration
REQ-031 SHALL, with macro FFT_STAGE_SCALE_EN defined, arithmetic-shift y0 and y1 right by 1 (floor) in every stage, giving overall 1/N scaling.
REQ-032 SHALL, without FFT_STAGE_SCALE_EN, apply no per-stage scaling.

Verification
REQ-033 SHALL cover impulse: defaults, table loaded with exact Q4.11 twiddles, x0=0x08000000, others 0 -> all 8 bins 0x08000000; with FFT_STAGE_SCALE_EN -> all 0x01000000.
REQ-034 SHALL cover DC: all 8 inputs 0x08000000, no scaling -> bin0=0x40000000, bins 1..7=0.
REQ-035 SHALL cover a sine: inputs re {0,0.919,1.3,0.919,0,-0.919,-1.3,-0.919}, im 0 -> bins 1 and 7 magnitude ≈5.2, other bins within 4 LSB of 0, matching a bit-accurate model exactly.
REQ-036 SHALL cover backpressure: out_ready toggled 1-0-0-1 through UNLOAD -> no bin lost or duplicated, out_last only on bin 7, busy falls the cycle after that transfer.
REQ-037 SHALL cover reset mid-CALC: rst_n low one cycle -> IDLE with outputs per REQ-029; the next frame is correct without reloading the twiddle table.
REQ-038 SHALL cover tw_we pulsed during CALC with garbage data -> the current frame result is unchanged.
